iterative_alu: RTL and testbench

//  Execute stage of the multi-cycle RV32I core, directly downstream of alu_control_unit.
//  - Consumes the 4-bit alu_op plus two XLEN-bit operands under a start/done handshake.
//  - Produces a registered result and a branch-condition flag.
//  - Logic/arith/compare ops finish in 1 cycle; shifts iterate 1 bit per cycle unless ALU_BARREL_SHIFT_EN.

---
 rtl/iterative_alu.sv | 245 ++++++++++++++++++++++++
 tb/tb_iterative_alu.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_alu.sv
// -----------------------------------------------------------------------------
// iterative_alu
//   Execute stage of the multi-cycle RV32I core. It accepts an alu_op and two
//   operands under a start/done handshake, and returns a registered result and
//   a registered branch-condition flag.
//   Logic, arithmetic and compare ops complete in one cycle. By default shifts
//   iterate one bit per cycle. When the macro ALU_BARREL_SHIFT_EN is defined,
//   shifts use a combinational barrel shifter and every op completes in one
//   cycle.
//
// Ports
//   clk         in   1     rising-edge clock
//   reset       in   1     synchronous, active-high reset
//   start       in   1     request; accepted on an edge where start=1, busy=0
//   alu_op      in   4     operation code
//   alu_in_1    in   XLEN  operand A (rs1)
//   alu_in_2    in   XLEN  operand B (rs2 / imm / shamt)
//   busy        out  1     multi-cycle op in flight; start ignored while high
//   done        out  1     1-cycle pulse; result/bcond valid this cycle
//   alu_result  out  XLEN  registered result, held until next done
//   alu_bcond   out  1     registered branch condition, held until next done
// -----------------------------------------------------------------------------
module iterative_alu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_in_1,
    input  logic [XLEN-1:0] alu_in_2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] alu_result,
    output logic            alu_bcond
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_BNE = 4'b1001;
    localparam logic [3:0] OP_BLT = 4'b1010;
    localparam logic [3:0] OP_BGE = 4'b1011;

    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    diff;
    logic [XLEN-1:0]    op_result_c;
    logic               op_bcond_c;

    logic [XLEN-1:0]    result_q, result_d;
    logic               bcond_q,  bcond_d;
    logic               done_q,   done_d;

    assign shamt = alu_in_2[SHAMT_W-1:0];
    assign diff  = alu_in_1 - alu_in_2;

    // Single-cycle result for every op. In the iterative build, shift ops only
    // take this path when shamt is 0, so there they pass operand A through.
    always_comb begin
        op_result_c = '0;
        op_bcond_c  = 1'b0;
        case (alu_op)
            OP_ADD: op_result_c = alu_in_1 + alu_in_2;
            OP_SUB: op_result_c = diff;
            OP_AND: op_result_c = alu_in_1 & alu_in_2;
            OP_OR:  op_result_c = alu_in_1 | alu_in_2;
            OP_XOR: op_result_c = alu_in_1 ^ alu_in_2;
`ifdef ALU_BARREL_SHIFT_EN
            OP_SLL: op_result_c = alu_in_1 << shamt;
            OP_SRL: op_result_c = alu_in_1 >> shamt;
            OP_SRA: op_result_c = XLEN'($signed(alu_in_1) >>> shamt);
`else
            OP_SLL, OP_SRL, OP_SRA: op_result_c = alu_in_1;
`endif
            OP_BEQ: begin
                op_result_c = diff;
                op_bcond_c  = (alu_in_1 == alu_in_2);
            end
            OP_BNE: begin
                op_result_c = diff;
                op_bcond_c  = (alu_in_1 != alu_in_2);
            end
            OP_BLT: begin
                op_result_c = diff;
                op_bcond_c  = ($signed(alu_in_1) < $signed(alu_in_2));
            end
            OP_BGE: begin
                op_result_c = diff;
                op_bcond_c  = ($signed(alu_in_1) >= $signed(alu_in_2));
            end
            default: begin
                op_result_c = '0;
                op_bcond_c  = 1'b0;
            end
        endcase
    end

`ifdef ALU_BARREL_SHIFT_EN

    // Every op completes in one cycle, so there is no FSM and busy is never set.
    always_comb begin
        result_d = result_q;
        bcond_d  = bcond_q;
        done_d   = 1'b0;
        if (start) begin
            result_d = op_result_c;
            bcond_d  = op_bcond_c;
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            bcond_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            bcond_q  <= bcond_d;
            done_q   <= done_d;
        end
    end

    assign busy = 1'b0;

`else

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q,   cnt_d;
    logic [XLEN-1:0]    shreg_q, shreg_d;
    logic [1:0]         shop_q,  shop_d;
    logic               busy_q,  busy_d;
    logic               accept;
    logic               is_shift;
    logic               go_shift;
    logic [XLEN-1:0]    shift_step;

    assign accept   = start & ~busy_q;
    assign is_shift = (alu_op == OP_SLL) | (alu_op == OP_SRL) | (alu_op == OP_SRA);
    assign go_shift = accept & is_shift & (shamt != '0);

    // One-bit step of the operand being shifted; shop_q holds alu_op[1:0].
    always_comb begin
        case (shop_q)
            2'b01:   shift_step = {shreg_q[XLEN-2:0], 1'b0};
            2'b10:   shift_step = {1'b0, shreg_q[XLEN-1:1]};
            default: shift_step = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            shop_q   <= 2'b00;
            busy_q   <= 1'b0;
            result_q <= '0;
            bcond_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            shop_q   <= shop_d;
            busy_q   <= busy_d;
            result_q <= result_d;
            bcond_q  <= bcond_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go_shift) state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == SHAMT_W'(1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        result_d = result_q;
        bcond_d  = bcond_q;
        done_d   = 1'b0;
        busy_d   = 1'b0;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        shop_d   = shop_q;
        case (state_q)
            S_IDLE: begin
                if (go_shift) begin
                    shreg_d = alu_in_1;
                    cnt_d   = shamt;
                    shop_d  = alu_op[1:0];
                    busy_d  = 1'b1;
                end else if (accept) begin
                    result_d = op_result_c;
                    bcond_d  = op_bcond_c;
                    done_d   = 1'b1;
                end
            end
            S_SHIFT: begin
                shreg_d = shift_step;
                cnt_d   = cnt_q - SHAMT_W'(1);
                busy_d  = 1'b1;
                // Last step: publish the shifted value directly.
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d = shift_step;
                    bcond_d  = 1'b0;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign busy = busy_q;

`endif

    assign done       = done_q;
    assign alu_result = result_q;
    assign alu_bcond  = bcond_q;

endmodule

// File: tb/tb_iterative_alu.sv
module tb_iterative_alu;

    localparam int unsigned XLEN = 32;
`ifdef ALU_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_in_1;
    logic [XLEN-1:0] alu_in_2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] alu_result;
    logic            alu_bcond;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iterative_alu #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .alu_op     (alu_op),
        .alu_in_1   (alu_in_1),
        .alu_in_2   (alu_in_2),
        .busy       (busy),
        .done       (done),
        .alu_result (alu_result),
        .alu_bcond  (alu_bcond)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        bc;
    } vec_t;

    vec_t tbl[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the op rules; ext = edges after the
    // accept edge until done is visible.
    function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic bc, output int ext);
        int unsigned sh;
        sh  = b % 32;
        r   = 32'd0;
        bc  = 1'b0;
        ext = 0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << sh;
            4'd6:  r = a >> sh;
            4'd7:  r = 32'($signed(a) >>> sh);
            4'd8:  begin r = a - b; bc = (a == b); end
            4'd9:  begin r = a - b; bc = (a != b); end
            4'd10: begin r = a - b; bc = ($signed(a) < $signed(b)); end
            4'd11: begin r = a - b; bc = ($signed(a) >= $signed(b)); end
            default: ;
        endcase
        if (op >= 4'd5 && op <= 4'd7 && sh != 0 && !BARREL) ext = int'(sh);
    endfunction

    // Issue one op on the next edge and wait (bounded) for done.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit noise, output logic [31:0] r, output logic bc,
                          output int ext, output int busy_cnt, output bit ok);
        @(negedge clk);
        start = 1'b1; alu_op = op; alu_in_1 = a; alu_in_2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        ext = 0; busy_cnt = 0; ok = 1'b1;
        while (!done) begin
            if (busy) busy_cnt++;
            if (ext >= 100) begin ok = 1'b0; break; end
            if (noise) begin
                @(negedge clk);
                start    = 1'($urandom_range(0, 1));
                alu_op   = 4'($urandom);
                alu_in_1 = $urandom;
                alu_in_2 = $urandom;
            end
            @(posedge clk); #1;
            start = 1'b0;
            ext++;
        end
        r  = alu_result;
        bc = alu_bcond;
    endtask

    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit noise);
        logic [31:0] er, r;
        logic        ebc, bc;
        int          eext, ext, bcnt;
        bit          ok;
        model(op, a, b, er, ebc, eext);
        run_op(op, a, b, noise, r, bc, ext, bcnt, ok);
        check({tag, " timeout"}, 32'(ok), 32'd1);
        check({tag, " result"}, r, er);
        check({tag, " bcond"}, 32'(bc), 32'(ebc));
        check({tag, " latency"}, 32'(ext), 32'(eext));
        check({tag, " busy cycles"}, 32'(bcnt), 32'(eext));
    endtask

    initial begin
        int pulses;
        logic [31:0] last;

        tbl[0]  = '{4'h0, 32'd5,         32'd7,         32'd12,        1'b0};
        tbl[1]  = '{4'h1, 32'd3,         32'd5,         32'hFFFFFFFE,  1'b0};
        tbl[2]  = '{4'hA, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFE,  1'b1};
        tbl[3]  = '{4'hB, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFE,  1'b0};
        tbl[4]  = '{4'h8, 32'd9,         32'd9,         32'd0,         1'b1};
        tbl[5]  = '{4'h9, 32'd9,         32'd9,         32'd0,         1'b0};
        tbl[6]  = '{4'h9, 32'd1,         32'd2,         32'hFFFFFFFF,  1'b1};
        tbl[7]  = '{4'h2, 32'h0000F0F0,  32'h0000FF00,  32'h0000F000,  1'b0};
        tbl[8]  = '{4'h3, 32'h0000F0F0,  32'h0000FF00,  32'h0000FFF0,  1'b0};
        tbl[9]  = '{4'h4, 32'h0000F0F0,  32'h0000FF00,  32'h00000FF0,  1'b0};
        tbl[10] = '{4'h0, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b0};
        tbl[11] = '{4'h7, 32'h80000000,  32'd4,         32'hF8000000,  1'b0};
        tbl[12] = '{4'h6, 32'h80000000,  32'd4,         32'h08000000,  1'b0};
        tbl[13] = '{4'h5, 32'h12345678,  32'h00000020,  32'h12345678,  1'b0};
        tbl[14] = '{4'hC, 32'd5,         32'd5,         32'd0,         1'b0};
        tbl[15] = '{4'hF, 32'hFFFFFFFF,  32'd0,         32'd0,         1'b0};
        tbl[16] = '{4'hA, 32'd1,         32'hFFFFFFFF,  32'd2,         1'b0};
        tbl[17] = '{4'hB, 32'h7FFFFFFF,  32'h80000000,  32'hFFFFFFFF,  1'b1};

        // Reset state, with start asserted to confirm reset wins.
        reset = 1'b1; start = 1'b1; alu_op = 4'h0; alu_in_1 = 32'd5; alu_in_2 = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", alu_result, 32'd0);
        check("reset bcond", 32'(alu_bcond), 32'd0);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;

        // Table vectors, including expected latency/busy from the model.
        for (int i = 0; i < 18; i++) begin
            logic [31:0] r, er;
            logic        bc, ebc;
            int          ext, eext, bcnt;
            bit          ok;
            model(tbl[i].op, tbl[i].a, tbl[i].b, er, ebc, eext);
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, r, bc, ext, bcnt, ok);
            check($sformatf("tbl%0d timeout", i), 32'(ok), 32'd1);
            check($sformatf("tbl%0d result", i), r, tbl[i].res);
            check($sformatf("tbl%0d bcond", i), 32'(bc), 32'(tbl[i].bc));
            check($sformatf("tbl%0d latency", i), 32'(ext), 32'(eext));
            check($sformatf("tbl%0d busy", i), 32'(busy), 32'd0);
        end

        // Long shift, then verify done is a single pulse and result holds.
        do_op("sll31", 4'h5, 32'd1, 32'd31, 1'b0);
        @(posedge clk); #1;
        check("sll31 done pulse", 32'(done), 32'd0);
        check("sll31 hold", alu_result, 32'h80000000);

        // Start while busy is ignored.
        @(negedge clk);
        start = 1'b1; alu_op = 4'h6; alu_in_1 = 32'hF0000000; alu_in_2 = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = done ? 1 : 0;
        last = alu_result;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 3) begin
                start = 1'b1; alu_op = 4'h0; alu_in_1 = 32'd1; alu_in_2 = 32'd2;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin pulses++; last = alu_result; end
        end
        check("busy-start pulses", 32'(pulses), BARREL ? 32'd2 : 32'd1);
        check("busy-start result", last, BARREL ? 32'd3 : 32'h003C0000);

        // Reset in the middle of a 20-cycle shift.
        @(negedge clk);
        start = 1'b1; alu_op = 4'h5; alu_in_1 = 32'h0000FFFF; alu_in_2 = 32'd20;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset result", alu_result, 32'd0);
        check("midreset bcond", 32'(alu_bcond), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("midreset no done", 32'(pulses), 32'd0);
        do_op("post-reset add", 4'h0, 32'd1, 32'd1, 1'b0);

        // Randomized back-to-back ops against the model, with start noise while busy.
        for (int i = 0; i < 150; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 1) == 1) b = 32'($urandom_range(0, 33));
            if ($urandom_range(0, 3) == 0) a = 32'h80000000 | a;
            do_op($sformatf("rnd%0d", i), op, a, b, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
